// File: rtl/dbus_xbar_param.sv
// Table-decoded data-bus interconnect between the LSU and NUM_SLAVES peripherals.
// One transaction in flight: IDLE captures, ACCESS waits for the slave ack, RESP returns the result.
module dbus_xbar_param #(
  parameter int NUM_SLAVES     = 6,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE = '0,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK = '0,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             lsu_req_i,
  input  logic                             lsu_we_i,
  input  logic [1:0]                       lsu_size_i,
  input  logic [ADDR_WIDTH-1:0]            lsu_addr_i,
  input  logic [DATA_WIDTH-1:0]            lsu_wdata_i,
  output logic                             lsu_ack_o,
  output logic                             lsu_err_o,
  output logic [DATA_WIDTH-1:0]            lsu_rdata_o,
  output logic [NUM_SLAVES-1:0]            peri_sel_o,
  output logic                             peri_we_o,
  output logic [ADDR_WIDTH-1:0]            peri_addr_o,
  output logic [DATA_WIDTH-1:0]            peri_wdata_o,
  output logic [DATA_WIDTH/8-1:0]          peri_be_o,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] peri_rdata_i,
  input  logic [NUM_SLAVES-1:0]            peri_ack_i,
  output logic [7:0]                       err_count_o
);

  localparam int BE_W   = DATA_WIDTH / 8;
  localparam int LANE_W = $clog2(BE_W);
  localparam int IDX_W  = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  logic [1:0]            state_q,   state_d;
  logic [ADDR_WIDTH-1:0] addr_q,    addr_d;
  logic                  we_q,      we_d;
  logic [DATA_WIDTH-1:0] wdata_q,   wdata_d;
  logic [BE_W-1:0]       be_q,      be_d;
  logic [IDX_W-1:0]      idx_q,     idx_d;
  logic [NUM_SLAVES-1:0] sel_q,     sel_d;
  logic [15:0]           cnt_q,     cnt_d;
  logic                  err_q,     err_d;
  logic [DATA_WIDTH-1:0] rdata_q,   rdata_d;
  logic [7:0]            err_cnt_q, err_cnt_d;

  logic                  hit;
  logic [IDX_W-1:0]      hit_idx;
  logic                  misaligned;
  logic [LANE_W-1:0]     lane;
  logic [BE_W-1:0]       be_base;
  logic [DATA_WIDTH-1:0] data_mask;
  logic [15:0]           cnt_inc;
  logic [DATA_WIDTH-1:0] slave_rdata;

  // Scan downwards so the lowest matching index is the one left standing.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((lsu_addr_i & SLAVE_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
          SLAVE_BASE[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    lane       = lsu_addr_i[LANE_W-1:0];
    misaligned = 1'b0;
    be_base    = '0;
    data_mask  = '0;
    case (lsu_size_i)
      2'b00: begin
        be_base   = BE_W'(1);
        data_mask = DATA_WIDTH'(8'hFF);
      end
      2'b01: begin
        misaligned = lsu_addr_i[0];
        be_base    = BE_W'(3);
        data_mask  = DATA_WIDTH'(16'hFFFF);
      end
      2'b10: begin
        misaligned = |lsu_addr_i[1:0];
        be_base    = BE_W'(15);
        data_mask  = DATA_WIDTH'(32'hFFFF_FFFF);
      end
      default: begin
        misaligned = (DATA_WIDTH != 64) || (|lsu_addr_i[2:0]);
        be_base    = '1;
        data_mask  = '1;
      end
    endcase
  end

  assign cnt_inc     = cnt_q + 16'd1;
  assign slave_rdata = peri_rdata_i[int'(idx_q)*DATA_WIDTH +: DATA_WIDTH];

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    idx_d     = idx_q;
    sel_d     = sel_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    rdata_d   = rdata_q;
    err_cnt_d = err_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (lsu_req_i) begin
          addr_d  = lsu_addr_i;
          we_d    = lsu_we_i;
          wdata_d = (lsu_wdata_i & data_mask) << {lane, 3'b000};
          be_d    = be_base << lane;
          cnt_d   = '0;
          rdata_d = '0;
          if (!hit || misaligned) begin
            state_d = ST_RESP;
            err_d   = 1'b1;
            sel_d   = '0;
          end else begin
            state_d = ST_ACCESS;
            err_d   = 1'b0;
            idx_d   = hit_idx;
            sel_d   = NUM_SLAVES'(1) << hit_idx;
          end
        end
      end
      ST_ACCESS: begin
        if (peri_ack_i[idx_q]) begin
          state_d = ST_RESP;
          err_d   = 1'b0;
          rdata_d = we_q ? '0 : slave_rdata;
          sel_d   = '0;
        end else if (cnt_inc >= TIMEOUT_LIMIT) begin
          state_d = ST_RESP;
          err_d   = 1'b1;
          rdata_d = '0;
          sel_d   = '0;
          cnt_d   = cnt_inc;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        if (err_q && (err_cnt_q != 8'hFF)) begin
          err_cnt_d = err_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        sel_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      be_q      <= '0;
      idx_q     <= '0;
      sel_q     <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      idx_q     <= idx_d;
      sel_q     <= sel_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // Response fields are only meaningful alongside the ack pulse, so keep them quiet otherwise.
  assign lsu_ack_o    = (state_q == ST_RESP);
  assign lsu_err_o    = lsu_ack_o & err_q;
  assign lsu_rdata_o  = lsu_ack_o ? rdata_q : '0;
  assign peri_sel_o   = sel_q;
  assign peri_we_o    = we_q & (state_q == ST_ACCESS);
  assign peri_addr_o  = addr_q;
  assign peri_wdata_o = wdata_q;
  assign peri_be_o    = be_q;
  assign err_count_o  = err_cnt_q;

endmodule

// File: tb/tb_dbus_xbar_param.sv
// Scoreboard bench for dbus_xbar_param: six slaves, 32-bit bus, short timeout.
// Expected responses are queued at issue time and retired by the ack monitor.
module tb_dbus_xbar_param;

  localparam int NS = 6;
  localparam int AW = 32;
  localparam int DW = 32;
  // Slave 0 is a coarse 0x2xxx_xxxx window that overlaps slave 3.
  localparam logic [NS*AW-1:0] BASES = {32'h7000_0000, 32'h6000_0000, 32'h2000_0000,
                                        32'h4000_0000, 32'h1000_0000, 32'h2000_0000};
  localparam logic [NS*AW-1:0] MASKS = {32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000,
                                        32'hFFFF_0000, 32'hFFFF_0000, 32'hF000_0000};

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          lsu_req_i, lsu_we_i;
  logic [1:0]    lsu_size_i;
  logic [31:0]   lsu_addr_i, lsu_wdata_i;
  logic          lsu_ack_o, lsu_err_o;
  logic [31:0]   lsu_rdata_o;
  logic [NS-1:0] peri_sel_o;
  logic          peri_we_o;
  logic [31:0]   peri_addr_o, peri_wdata_o;
  logic [3:0]    peri_be_o;
  logic [NS*DW-1:0] peri_rdata_i;
  logic [NS-1:0] peri_ack_i;
  logic [7:0]    err_count_o;

  logic [NS-1:0] ack_auto_en;
  logic [NS-1:0] ack_force;

  exp_t exp_q[$];
  int   checks = 0;
  int   passes = 0;

  always #5 clk = ~clk;

  dbus_xbar_param #(
    .NUM_SLAVES(NS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .SLAVE_BASE(BASES), .SLAVE_MASK(MASKS), .TIMEOUT_CYCLES(4)
  ) dut (
    .clk(clk), .rst(rst),
    .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_size_i(lsu_size_i),
    .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i),
    .lsu_ack_o(lsu_ack_o), .lsu_err_o(lsu_err_o), .lsu_rdata_o(lsu_rdata_o),
    .peri_sel_o(peri_sel_o), .peri_we_o(peri_we_o), .peri_addr_o(peri_addr_o),
    .peri_wdata_o(peri_wdata_o), .peri_be_o(peri_be_o),
    .peri_rdata_i(peri_rdata_i), .peri_ack_i(peri_ack_i),
    .err_count_o(err_count_o)
  );

  // Zero-wait slaves: each acks combinationally while selected, unless disabled.
  assign peri_ack_i = (peri_sel_o & ack_auto_en) | ack_force;

  always_comb begin
    peri_rdata_i = '0;
    for (int i = 0; i < NS; i++) begin
      peri_rdata_i[i*DW +: DW] = 32'hA000_005A | (32'(i) << 8);
    end
  end

  // Every ack must retire exactly one queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (lsu_ack_o) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("[TB] FAIL unexpected_ack: got ack err=%0b rdata=%h, want no ack", lsu_err_o, lsu_rdata_o);
      end else begin
        e = exp_q.pop_front();
        checks++;
        if (lsu_err_o !== e.err)
          $display("[TB] FAIL resp_err: got %0b, want %0b", lsu_err_o, e.err);
        else passes++;
        checks++;
        if (lsu_rdata_o !== e.rdata)
          $display("[TB] FAIL resp_rdata: got %h, want %h", lsu_rdata_o, e.rdata);
        else passes++;
      end
    end
  end

  task automatic issue(input logic we, input logic [1:0] size, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic exp_err, input logic [31:0] exp_rdata);
    exp_t e;
    lsu_req_i   = 1'b1;
    lsu_we_i    = we;
    lsu_size_i  = size;
    lsu_addr_i  = addr;
    lsu_wdata_i = wdata;
    e.err   = exp_err;
    e.rdata = exp_rdata;
    exp_q.push_back(e);
  endtask

  // Observes one transaction up to its ack; edges = 99 if the ack never came.
  task automatic wait_ack(output int edges, output logic [NS-1:0] first_sel, output logic [3:0] first_be,
                          output logic [31:0] first_wdata, output logic first_we,
                          output logic sel_seen, output logic [NS-1:0] ack_sel);
    edges = 0; sel_seen = 1'b0; ack_sel = '0;
    first_sel = '0; first_be = '0; first_wdata = '0; first_we = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (k == 0) begin
        first_sel = peri_sel_o; first_be = peri_be_o;
        first_wdata = peri_wdata_o; first_we = peri_we_o;
      end
      sel_seen = sel_seen | (|peri_sel_o);
      if (lsu_ack_o) begin
        ack_sel = peri_sel_o;
        break;
      end
    end
    if (!lsu_ack_o) edges = 99;
  endtask

  task automatic finish_txn();
    lsu_req_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({lsu_ack_o, lsu_err_o, peri_sel_o, peri_we_o, peri_be_o} !== '0)
      $display("[TB] FAIL reset_ctrl: got ack=%0b err=%0b sel=%b we=%0b be=%b, want all 0",
               lsu_ack_o, lsu_err_o, peri_sel_o, peri_we_o, peri_be_o);
    else passes++;
    checks++;
    if (peri_addr_o !== 32'h0) $display("[TB] FAIL reset_addr: got %h, want 0", peri_addr_o);
    else passes++;
    checks++;
    if (peri_wdata_o !== 32'h0) $display("[TB] FAIL reset_wdata: got %h, want 0", peri_wdata_o);
    else passes++;
    checks++;
    if (lsu_rdata_o !== 32'h0) $display("[TB] FAIL reset_rdata: got %h, want 0", lsu_rdata_o);
    else passes++;
    checks++;
    if (err_count_o !== 8'd0) $display("[TB] FAIL reset_errcnt: got %0d, want 0", err_count_o);
    else passes++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_store_word();
    int edges; logic [NS-1:0] fs, as; logic [3:0] fb; logic [31:0] fw; logic fwe, ss;
    issue(1'b1, 2'b10, 32'h4000_0008, 32'hA5A5_1234, 1'b0, 32'h0);
    wait_ack(edges, fs, fb, fw, fwe, ss, as);
    checks++;
    if (edges !== 2) $display("[TB] FAIL sw_latency: got %0d edges, want 2", edges); else passes++;
    checks++;
    if (fs !== 6'b000100) $display("[TB] FAIL sw_sel: got %b, want 000100", fs); else passes++;
    checks++;
    if (fb !== 4'hF) $display("[TB] FAIL sw_be: got %b, want 1111", fb); else passes++;
    checks++;
    if (fw !== 32'hA5A5_1234) $display("[TB] FAIL sw_wdata: got %h, want a5a51234", fw); else passes++;
    checks++;
    if (fwe !== 1'b1) $display("[TB] FAIL sw_we: got %0b, want 1", fwe); else passes++;
    checks++;
    if (as !== '0) $display("[TB] FAIL sw_sel_in_resp: got %b, want 0", as); else passes++;
    finish_txn();
  endtask

  task automatic test_byte_lanes();
    int edges; logic [NS-1:0] fs, as; logic [3:0] fb; logic [31:0] fw; logic fwe, ss;
    issue(1'b1, 2'b00, 32'h4000_0003, 32'h1234_565A, 1'b0, 32'h0);
    wait_ack(edges, fs, fb, fw, fwe, ss, as);
    checks++;
    if (fb !== 4'b1000) $display("[TB] FAIL sb_be: got %b, want 1000", fb); else passes++;
    checks++;
    if (fw !== 32'h5A00_0000) $display("[TB] FAIL sb_wdata: got %h, want 5a000000", fw); else passes++;
    finish_txn();

    issue(1'b1, 2'b01, 32'h4000_0002, 32'hFFFF_BEEF, 1'b0, 32'h0);
    wait_ack(edges, fs, fb, fw, fwe, ss, as);
    checks++;
    if (fb !== 4'b1100) $display("[TB] FAIL sh_be: got %b, want 1100", fb); else passes++;
    checks++;
    if (fw !== 32'hBEEF_0000) $display("[TB] FAIL sh_wdata: got %h, want beef0000", fw); else passes++;
    finish_txn();

    issue(1'b1, 2'b01, 32'h4000_0001, 32'h0000_1111, 1'b1, 32'h0);
    wait_ack(edges, fs, fb, fw, fwe, ss, as);
    checks++;
    if (edges !== 1) $display("[TB] FAIL misalign_latency: got %0d edges, want 1", edges); else passes++;
    checks++;
    if (ss !== 1'b0) $display("[TB] FAIL misalign_sel: got sel asserted, want never"); else passes++;
    finish_txn();
    checks++;
    if (err_count_o !== 8'd1) $display("[TB] FAIL misalign_errcnt: got %0d, want 1", err_count_o); else passes++;
  endtask

  task automatic test_load();
    int edges; logic [NS-1:0] fs, as; logic [3:0] fb; logic [31:0] fw; logic fwe, ss;
    issue(1'b0, 2'b00, 32'h4000_0006, 32'hFFFF_FFFF, 1'b0, 32'hA000_025A);
    wait_ack(edges, fs, fb, fw, fwe, ss, as);
    checks++;
    if (fb !== 4'b0100) $display("[TB] FAIL lb_be: got %b, want 0100", fb); else passes++;
    checks++;
    if (fwe !== 1'b0) $display("[TB] FAIL lb_we: got %0b, want 0", fwe); else passes++;
    checks++;
    if (edges !== 2) $display("[TB] FAIL lb_latency: got %0d edges, want 2", edges); else passes++;
    finish_txn();
  endtask

  task automatic test_decode_miss();
    int edges; logic [NS-1:0] fs, as; logic [3:0] fb; logic [31:0] fw; logic fwe, ss;
    issue(1'b0, 2'b10, 32'h9000_0000, 32'h0, 1'b1, 32'h0);
    wait_ack(edges, fs, fb, fw, fwe, ss, as);
    checks++;
    if (edges !== 1) $display("[TB] FAIL miss_latency: got %0d edges, want 1", edges); else passes++;
    checks++;
    if (ss !== 1'b0) $display("[TB] FAIL miss_sel: got sel asserted, want never"); else passes++;
    finish_txn();
  endtask

  task automatic test_timeout();
    int edges; logic [NS-1:0] fs, as; logic [3:0] fb; logic [31:0] fw; logic fwe, ss;
    ack_auto_en = 6'b101111;
    issue(1'b0, 2'b10, 32'h6000_0000, 32'h0, 1'b1, 32'h0);
    wait_ack(edges, fs, fb, fw, fwe, ss, as);
    checks++;
    if (edges !== 5) $display("[TB] FAIL timeout_latency: got %0d edges, want 5", edges); else passes++;
    checks++;
    if (fs !== 6'b010000) $display("[TB] FAIL timeout_sel: got %b, want 010000", fs); else passes++;
    checks++;
    if (as !== '0) $display("[TB] FAIL timeout_sel_in_resp: got %b, want 0", as); else passes++;
    finish_txn();
    ack_auto_en = '1;
    checks++;
    if (err_count_o !== 8'd3) $display("[TB] FAIL timeout_errcnt: got %0d, want 3", err_count_o); else passes++;
  endtask

  task automatic test_priority();
    ack_auto_en = 6'b111110;
    ack_force   = 6'b001000;
    issue(1'b0, 2'b10, 32'h2000_0100, 32'h0, 1'b0, 32'hA000_005A);
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (peri_sel_o !== 6'b000001) $display("[TB] FAIL prio_sel: got %b, want 000001", peri_sel_o); else passes++;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (lsu_ack_o !== 1'b0) $display("[TB] FAIL prio_foreign_ack: got ack %0b, want 0", lsu_ack_o); else passes++;
    ack_auto_en = '1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (lsu_ack_o !== 1'b1) $display("[TB] FAIL prio_complete: got ack %0b, want 1", lsu_ack_o); else passes++;
    ack_force = '0;
    finish_txn();
  endtask

  task automatic test_back_to_back();
    int edges; logic [NS-1:0] fs, as; logic [3:0] fb; logic [31:0] fw; logic fwe, ss;
    issue(1'b0, 2'b10, 32'h4000_0004, 32'h0, 1'b0, 32'hA000_025A);
    wait_ack(edges, fs, fb, fw, fwe, ss, as);
    issue(1'b0, 2'b10, 32'h1000_0008, 32'h0, 1'b0, 32'hA000_015A);
    wait_ack(edges, fs, fb, fw, fwe, ss, as);
    checks++;
    if (edges !== 3) $display("[TB] FAIL b2b_latency: got %0d edges, want 3", edges); else passes++;
    finish_txn();
  endtask

  task automatic test_reset_mid_access();
    logic ack_seen;
    ack_auto_en = 6'b101111;
    lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_size_i = 2'b10;
    lsu_addr_i = 32'h6000_0000; lsu_wdata_i = 32'h0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    lsu_req_i = 1'b0;
    @(negedge clk);
    checks++;
    if (peri_sel_o !== 6'b010000) $display("[TB] FAIL rstmid_pre_sel: got %b, want 010000", peri_sel_o); else passes++;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({lsu_ack_o, lsu_err_o, peri_sel_o, peri_we_o, peri_be_o, peri_addr_o, peri_wdata_o} !== '0)
      $display("[TB] FAIL rstmid_outputs: got ack=%0b sel=%b be=%b addr=%h, want all 0",
               lsu_ack_o, peri_sel_o, peri_be_o, peri_addr_o);
    else passes++;
    checks++;
    if (err_count_o !== 8'd0) $display("[TB] FAIL rstmid_errcnt: got %0d, want 0", err_count_o); else passes++;
    rst = 1'b0;
    ack_seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      ack_seen = ack_seen | lsu_ack_o;
    end
    checks++;
    if (ack_seen !== 1'b0) $display("[TB] FAIL rstmid_no_ack: got ack after reset, want none"); else passes++;
    ack_auto_en = '1;
  endtask

  initial begin
    rst = 1'b1; lsu_req_i = 1'b0; lsu_we_i = 1'b0; lsu_size_i = 2'b00;
    lsu_addr_i = '0; lsu_wdata_i = '0;
    ack_auto_en = '1; ack_force = '0;
    test_reset();
    test_store_word();
    test_byte_lanes();
    test_load();
    test_decode_miss();
    test_timeout();
    test_priority();
    test_back_to_back();
    test_reset_mid_access();
    checks++;
    if (exp_q.size() != 0) $display("[TB] FAIL pending_resp: got %0d outstanding, want 0", exp_q.size());
    else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion, want finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
